// File: rtl/exec_mem_initiator.sv
// Execution-unit memory initiator: takes one memory-reference op at a time,
// resolves direct/indirect/autoindex effective addresses and performs the
// READ, WRITE or INCR (ISZ) access on the exec_rd_*/exec_wr_* port pair.
module exec_mem_initiator #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_ind_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [ADDR_WIDTH-1:0] rsp_ea_o,
    output logic                  rsp_skip_o,
    output logic                  exec_rd_req_o,
    output logic [ADDR_WIDTH-1:0] exec_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] exec_rd_data_i,
    output logic                  exec_wr_req_o,
    output logic [ADDR_WIDTH-1:0] exec_wr_addr_o,
    output logic [DATA_WIDTH-1:0] exec_wr_data_o
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_RD,
        S_PTR_CAP,
        S_OP_RD,
        S_OP_CAP,
        S_OP_WR,
        S_RSP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_ea_q, rsp_ea_d;
    logic          rsp_skip_q, rsp_skip_d;

    logic [DW-1:0] rd_inc;
    logic          autoidx;

    // A memory word used as an address keeps only the address-width bits.
    function automatic logic [AW-1:0] word_to_addr(input logic [DW-1:0] w);
        return AW'(w);
    endfunction

    // Memory word plus one, wrapping modulo 2^DW (ISZ and autoindex increment).
    assign rd_inc  = exec_rd_data_i + DW'(1);
    // Locations 0o10-0o17 are the autoindex registers.
    assign autoidx = (addr_q[AW-1:3] == (AW-3)'(1));

    // Next-state and datapath register updates for the access sequencer.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ea_d       = ea_q;
        rsp_data_d = rsp_data_q;
        rsp_ea_d   = rsp_ea_q;
        rsp_skip_d = rsp_skip_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    ea_d    = req_addr_i;
                    if (req_ind_i)
                        state_d = S_PTR_RD;
                    else if (req_op_i == OP_WRITE)
                        state_d = S_OP_WR;
                    else
                        state_d = S_OP_RD;
                end
            end
            S_PTR_RD: state_d = S_PTR_CAP;
            S_PTR_CAP: begin
                ea_d    = autoidx ? word_to_addr(rd_inc) : word_to_addr(exec_rd_data_i);
                state_d = (op_q == OP_WRITE) ? S_OP_WR : S_OP_RD;
            end
            S_OP_RD: state_d = S_OP_CAP;
            S_OP_CAP: begin
                rsp_ea_d = ea_q;
                if (op_q == OP_INCR) begin
                    rsp_data_d = rd_inc;
                    rsp_skip_d = (rd_inc == '0);
                end else begin
                    // READ and the reserved encoding both return the word as read.
                    rsp_data_d = exec_rd_data_i;
                    rsp_skip_d = 1'b0;
                end
                state_d = S_RSP;
            end
            S_OP_WR: begin
                rsp_data_d = wdata_q;
                rsp_ea_d   = ea_q;
                rsp_skip_d = 1'b0;
                state_d    = S_RSP;
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers; working operands are not reset since
    // they are always reloaded on accept before being used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rsp_data_q <= '0;
            rsp_ea_q   <= '0;
            rsp_skip_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_ea_q   <= rsp_ea_d;
            rsp_skip_q <= rsp_skip_d;
        end
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        ea_q    <= ea_d;
    end

    // Handshake and memory strobes decoded from state; held quiet during reset
    // so an abandoned op never reaches memory.
    always_comb begin
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        exec_rd_req_o  = 1'b0;
        exec_rd_addr_o = '0;
        exec_wr_req_o  = 1'b0;
        exec_wr_addr_o = '0;
        exec_wr_data_o = '0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: req_ready_o = 1'b1;
                S_PTR_RD: begin
                    exec_rd_req_o  = 1'b1;
                    exec_rd_addr_o = addr_q;
                end
                S_PTR_CAP: begin
                    if (autoidx) begin
                        exec_wr_req_o  = 1'b1;
                        exec_wr_addr_o = addr_q;
                        exec_wr_data_o = rd_inc;
                    end
                end
                S_OP_RD: begin
                    exec_rd_req_o  = 1'b1;
                    exec_rd_addr_o = ea_q;
                end
                S_OP_CAP: begin
                    if (op_q == OP_INCR) begin
                        exec_wr_req_o  = 1'b1;
                        exec_wr_addr_o = ea_q;
                        exec_wr_data_o = rd_inc;
                    end
                end
                S_OP_WR: begin
                    exec_wr_req_o  = 1'b1;
                    exec_wr_addr_o = ea_q;
                    exec_wr_data_o = wdata_q;
                end
                S_RSP:   rsp_valid_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_ea_o   = rsp_ea_q;
    assign rsp_skip_o = rsp_skip_q;

endmodule

// File: tb/tb_exec_mem_initiator.sv
// Testbench for exec_mem_initiator: behavioural memory, reference model of
// the op semantics, directed cases followed by randomized ops.
module tb_exec_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic        req_ind;
    logic [11:0] req_wdata;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic [11:0] rsp_ea;
    logic        rsp_skip;
    logic        exec_rd_req;
    logic [11:0] exec_rd_addr;
    logic [11:0] exec_rd_data;
    logic        exec_wr_req;
    logic [11:0] exec_wr_addr;
    logic [11:0] exec_wr_data;

    always #5 clk = ~clk;

    exec_mem_initiator #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_addr_i    (req_addr),
        .req_ind_i     (req_ind),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .rsp_ea_o      (rsp_ea),
        .rsp_skip_o    (rsp_skip),
        .exec_rd_req_o (exec_rd_req),
        .exec_rd_addr_o(exec_rd_addr),
        .exec_rd_data_i(exec_rd_data),
        .exec_wr_req_o (exec_wr_req),
        .exec_wr_addr_o(exec_wr_addr),
        .exec_wr_data_o(exec_wr_data)
    );

    // Behavioural memory with a backdoor port for preloading
    logic [11:0] mem [0:4095];
    logic        bd_clr, bd_we;
    logic [11:0] bd_addr, bd_data;

    always @(posedge clk) begin
        if (bd_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 12'h0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (exec_wr_req) begin
            mem[exec_wr_addr] <= exec_wr_data;
        end
        if (exec_rd_req) exec_rd_data <= mem[exec_rd_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: records every strobe and checks bus hygiene each cycle
    bit          mon_on = 1'b0;
    logic [24:0] obs_q[$];
    logic [24:0] exp_acc[$];

    always @(negedge clk) begin
        if (mon_on) begin
            chk("strobe_excl", {31'b0, exec_rd_req & exec_wr_req}, 32'd0);
            chk("bus_idle_zero",
                {31'b0, (|(exec_rd_req ? 12'h0 : exec_rd_addr)) |
                        (|(exec_wr_req ? 24'h0 : {exec_wr_addr, exec_wr_data}))}, 32'd0);
            if (exec_rd_req) obs_q.push_back({1'b0, exec_rd_addr, 12'h0});
            if (exec_wr_req) obs_q.push_back({1'b1, exec_wr_addr, exec_wr_data});
        end
    end

    // Reference model: architectural effect of one op on the reference memory
    logic [11:0] ref_mem [0:4095];

    task automatic ref_op(input logic [1:0] op, input logic [11:0] a, input logic ind,
                          input logic [11:0] wd, output logic [11:0] d, output logic [11:0] ea,
                          output logic sk, output int lat);
        logic [11:0] p, w;
        ea = a; sk = 1'b0; lat = 0; d = 12'h0;
        if (ind) begin
            p = ref_mem[a];
            exp_acc.push_back({1'b0, a, 12'h0});
            if (a >= 12'o10 && a <= 12'o17) begin
                p = p + 12'd1;
                ref_mem[a] = p;
                exp_acc.push_back({1'b1, a, p});
            end
            ea = p;
            lat = 2;
        end
        if (op == 2'b01) begin
            ref_mem[ea] = wd;
            exp_acc.push_back({1'b1, ea, wd});
            d = wd;
            lat += 2;
        end else if (op == 2'b10) begin
            w = ref_mem[ea] + 12'd1;
            exp_acc.push_back({1'b0, ea, 12'h0});
            exp_acc.push_back({1'b1, ea, w});
            ref_mem[ea] = w;
            d = w;
            sk = (w == 12'h0);
            lat += 3;
        end else begin
            exp_acc.push_back({1'b0, ea, 12'h0});
            d = ref_mem[ea];
            lat += 3;
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[a] = d;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [11:0] a, input logic ind,
                          input logic [11:0] wd);
        logic [11:0] e_data, e_ea;
        logic        e_skip;
        int          e_lat, lat, n;
        bit          got;
        lat = 0;
        while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        exp_acc.delete();
        obs_q.delete();
        ref_op(op, a, ind, wd, e_data, e_ea, e_skip, e_lat);
        req_valid = 1'b1; req_op = op; req_addr = a; req_ind = ind; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 12'($urandom);
        req_ind   = 1'($urandom);
        req_wdata = 12'($urandom);
        got = 1'b0; lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_seen", {31'b0, got}, 32'd1);
        if (got) begin
            chk("latency", lat, e_lat);
            chk("rsp_data", rsp_data, e_data);
            chk("rsp_ea", rsp_ea, e_ea);
            chk("rsp_skip", rsp_skip, e_skip);
        end
        chk("acc_count", obs_q.size(), exp_acc.size());
        n = (obs_q.size() < exp_acc.size()) ? obs_q.size() : exp_acc.size();
        for (int i = 0; i < n; i++) chk("acc_seq", obs_q[i], exp_acc[i]);
        chk("mem_ea", mem[e_ea], ref_mem[e_ea]);
        chk("mem_ptr", mem[a], ref_mem[a]);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 32'd0);
        chk("rsp_hold", rsp_data, e_data);
        chk("ready_after", req_ready, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [11:0] a;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 12'h0;
        req_ind = 1'b0; req_wdata = 12'h0;
        bd_clr = 1'b1; bd_we = 1'b0; bd_addr = 12'h0; bd_data = 12'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 12'h0;
        repeat (2) @(posedge clk);
        #1 bd_clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rd_req", exec_rd_req, 32'd0);
        chk("rst_wr_req", exec_wr_req, 32'd0);
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_ready", req_ready, 32'd1);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_ea", rsp_ea, 32'd0);
        chk("reset_rsp_skip", rsp_skip, 32'd0);

        // Directed cases
        poke(12'o200, 12'o1234);
        run_op(2'b00, 12'o200, 1'b0, 12'h0);
        run_op(2'b01, 12'o300, 1'b0, 12'o4321);
        run_op(2'b00, 12'o300, 1'b0, 12'h0);
        poke(12'o20, 12'o500);
        poke(12'o500, 12'o7);
        run_op(2'b00, 12'o20, 1'b1, 12'h0);
        poke(12'o10, 12'o7777);
        poke(12'o0, 12'o42);
        run_op(2'b00, 12'o10, 1'b1, 12'h0);
        poke(12'o400, 12'o7777);
        run_op(2'b10, 12'o400, 1'b0, 12'h0);
        poke(12'o400, 12'o5);
        run_op(2'b10, 12'o400, 1'b0, 12'h0);
        run_op(2'b11, 12'o400, 1'b0, 12'h0);
        poke(12'o11, 12'o10);
        run_op(2'b00, 12'o11, 1'b1, 12'h0);

        // Reset in the middle of an INCR: op abandoned, no write, no response
        poke(12'o400, 12'o5);
        req_valid = 1'b1; req_op = 2'b10; req_addr = 12'o400; req_ind = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        obs_q.delete();
        rst = 1'b1;
        #1;
        chk("midrst_rd_forced", exec_rd_req, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_wr", exec_wr_req, 32'd0);
            chk("midrst_rsp", rsp_valid, 32'd0);
            chk("midrst_ready", req_ready, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("midrst_ready_first", req_ready, 32'd1);
        chk("midrst_no_access", obs_q.size(), 32'd0);
        chk("midrst_mem", mem[12'o400], 32'o5);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        run_op(2'b10, 12'o400, 1'b0, 12'h0);

        // Randomized ops over a randomly preloaded memory
        for (int i = 0; i < 40; i++) poke(12'($urandom), 12'($urandom));
        for (int i = 8; i < 16; i++) poke(12'(i), 12'($urandom_range(0, 63)));
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 12'(8 + $urandom_range(0, 7));
                1:       a = 12'($urandom_range(0, 63));
                default: a = 12'($urandom);
            endcase
            op = 2'($urandom_range(0, 3));
            run_op(op, a, 1'($urandom_range(0, 1)), 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
